// File: rtl/vram_arbiter_pkg.sv
// Shared constants and state encodings for the VRAM arbiter slice.
// Display geometry is the 256x240 active area split into 8x8 character cells.
package vram_arbiter_pkg;

  localparam int H_DISPLAY   = 256;
  localparam int V_DISPLAY   = 240;
  localparam int DEF_CELL_SH = 3;
  localparam int MAP_COLS    = H_DISPLAY >> DEF_CELL_SH;
  localparam int MAP_ROWS    = V_DISPLAY >> DEF_CELL_SH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } cpu_state_e;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_DISP = 1'b1
  } owner_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU request/acknowledge port of the VRAM arbiter.
// The master holds req and its qualifiers stable until it sees a one-cycle ack.
interface vram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );

endinterface

// File: rtl/vram_cpu_port.sv
// CPU side of the VRAM arbiter: IDLE/BUSY/DONE handshake FSM, stall counter
// and read-data capture.
module vram_cpu_port
  import vram_arbiter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              live,
  input  logic              dslot,
  input  logic              rd_vld,
  input  logic [DATA_W-1:0] ram_rdata,
  vram_arbiter_if.slave     cpu,
  output logic              cpu_issue,
  output logic [STAT_W-1:0] cpu_stalls
);

  cpu_state_e        state_p0;
  cpu_state_e        state_nxt;
  logic              stall_inc;
  logic              ack;
  logic              rd_capture;
  logic [DATA_W-1:0] rdata_p1;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_p0 <= ST_IDLE;
    else        state_p0 <= state_nxt;
  end

  // The display owns the RAM on a slot, so a pending request just waits and is counted.
  always_comb begin
    state_nxt = state_p0;
    cpu_issue = 1'b0;
    stall_inc = 1'b0;
    ack       = 1'b0;
    unique case (state_p0)
      ST_IDLE: begin
        if (live && cpu.cpu_req) begin
          if (dslot) begin
            stall_inc = 1'b1;
          end else begin
            cpu_issue = 1'b1;
            state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        ack       = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cpu.cpu_ack = ack;

  // --- p1: RAM return for a CPU read, bypassed during ack and held afterwards
  assign rd_capture = rd_vld && !cpu.cpu_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          rdata_p1 <= '0;
    else if (rd_capture) rdata_p1 <= ram_rdata;
  end

  assign cpu.cpu_rdata = rd_capture ? ram_rdata : rdata_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         cpu_stalls <= '0;
    else if (stall_inc) cpu_stalls <= sat_inc(cpu_stalls);
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed display fetch slots every 8th pixel of the
// active area, CPU accesses in the remaining cycles through a req/ack port.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int CELL_SH = DEF_CELL_SH,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        hpos,
  input  logic [8:0]        vpos,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  vram_arbiter_if.slave     cpu,
  output logic [STAT_W-1:0] cpu_stalls,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic              live_p0;
  logic              dslot;
  logic              disp_issue;
  logic              cpu_issue;
  logic [ADDR_W-1:0] disp_addr;
  logic              vld_p1;
  owner_e            owner_p1;
  logic              cpu_rd_vld;
  logic [DATA_W-1:0] disp_data_p1;

  // Accesses are held off for the first cycle after reset release so that no
  // RAM strobe is ever derived combinationally from the reset pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) live_p0 <= 1'b0;
    else        live_p0 <= 1'b1;
  end

  assign dslot      = !hpos[8] && (vpos < 9'(V_DISPLAY)) && (hpos[CELL_SH-1:0] == '0);
  assign disp_issue = live_p0 && dslot;
  assign disp_addr  = ADDR_W'({vpos[7:CELL_SH], hpos[7:CELL_SH]});

  vram_cpu_port #(
    .DATA_W (DATA_W),
    .STAT_W (STAT_W)
  ) u_cpu_port (
    .clk        (clk),
    .reset      (reset),
    .live       (live_p0),
    .dslot      (dslot),
    .rd_vld     (cpu_rd_vld),
    .ram_rdata  (ram_rdata),
    .cpu        (cpu),
    .cpu_issue  (cpu_issue),
    .cpu_stalls (cpu_stalls)
  );

  // --- p0: address mux, display strictly first
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (disp_issue) begin
      ram_en   = 1'b1;
      ram_addr = disp_addr;
    end else if (cpu_issue) begin
      ram_en    = 1'b1;
      ram_we    = cpu.cpu_we;
      ram_addr  = cpu.cpu_addr;
      ram_wdata = cpu.cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      owner_p1 <= OWN_CPU;
    end else begin
      vld_p1   <= ram_en;
      owner_p1 <= disp_issue ? OWN_DISP : OWN_CPU;
    end
  end

  // --- p1: owner tag steers the RAM return
  assign disp_valid = vld_p1 && (owner_p1 == OWN_DISP);
  assign cpu_rd_vld = vld_p1 && (owner_p1 == OWN_CPU);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          disp_data_p1 <= '0;
    else if (disp_valid) disp_data_p1 <= ram_rdata;
  end

  assign disp_data = disp_valid ? ram_rdata : disp_data_p1;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios followed by randomized CPU
// traffic over a scanning raster, checked cycle by cycle against a slot/latency model.
module tb_vram_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int STAT_W = 16;
  localparam int SAT_W  = 4;
  localparam int MAXS   = (1 << STAT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [8:0]        hpos, vpos;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic [STAT_W-1:0] cpu_stalls;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cif ();

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CELL_SH(3), .STAT_W(STAT_W)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .disp_data(disp_data), .disp_valid(disp_valid), .cpu(cif), .cpu_stalls(cpu_stalls),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Narrow-counter instance used only to reach stall-counter saturation quickly.
  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();
  logic [DATA_W-1:0] sat_disp_data, sat_wdata;
  logic              sat_disp_valid, sat_en, sat_we;
  logic [SAT_W-1:0]  sat_stalls;
  logic [ADDR_W-1:0] sat_addr;
  logic [DATA_W-1:0] sat_rdata;
  assign sat_rdata = '0;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CELL_SH(3), .STAT_W(SAT_W)) sat_dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .disp_data(sat_disp_data), .disp_valid(sat_disp_valid), .cpu(sif), .cpu_stalls(sat_stalls),
    .ram_en(sat_en), .ram_we(sat_we), .ram_addr(sat_addr), .ram_wdata(sat_wdata),
    .ram_rdata(sat_rdata)
  );

  // VRAM macro: registered read, one cycle after the strobe.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              seed_mem;
  int unsigned       salt;

  function automatic logic [DATA_W-1:0] seed_val(input int i, input int unsigned s);
    return DATA_W'((i * 73 + 29) ^ (i >> 3) ^ int'(s));
  endfunction

  always @(posedge clk) begin
    if (seed_mem) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= seed_val(i, salt);
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // Checking bookkeeping
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state: contents, pending returns, CPU spacing and stall count.
  logic [DATA_W-1:0] gold [0:(1<<ADDR_W)-1];
  bit                m_live, m_dv, m_ack, m_ack_rd;
  logic [DATA_W-1:0] m_dd, m_rd;
  int                m_hold, m_stalls;

  // Snapshot of the last sampled cycle
  logic              s_en, s_we, s_dv, s_ack;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata, s_dd, s_rd;
  logic [STAT_W-1:0] s_stalls;
  int                s_hpos;
  int                cyc = 0;
  bit                scan_en;

  task automatic cycle();
    int h, v;
    bit ds, nxt_dv, nxt_ack;
    logic [ADDR_W-1:0] da;
    #2;
    s_en = ram_en; s_we = ram_we; s_addr = ram_addr; s_wdata = ram_wdata;
    s_dv = disp_valid; s_dd = disp_data; s_ack = cif.cpu_ack; s_rd = cif.cpu_rdata;
    s_stalls = cpu_stalls; s_hpos = int'(hpos);
    if (!reset) begin
      chk("rst_disp_valid", s_dv, 0);
      chk("rst_disp_data", s_dd, 0);
      chk("rst_cpu_ack", s_ack, 0);
      chk("rst_cpu_rdata", s_rd, 0);
      chk("rst_cpu_stalls", s_stalls, 0);
      chk("rst_ram_en", s_en, 0);
      m_live = 0; m_dv = 0; m_ack = 0; m_hold = 0; m_stalls = 0;
    end else begin
      chk("disp_valid", s_dv, m_dv);
      if (m_dv) chk("disp_data", s_dd, m_dd);
      chk("cpu_ack", s_ack, m_ack);
      if (m_ack && m_ack_rd) chk("cpu_rdata", s_rd, m_rd);
      chk("cpu_stalls", s_stalls, m_stalls);
      h  = int'(hpos);
      v  = int'(vpos);
      ds = (h < 256) && (v < 240) && (h % 8 == 0);
      da = ADDR_W'((v / 8) * 32 + h / 8);
      nxt_dv = 0; nxt_ack = 0;
      if (!m_live) begin
        chk("first_cycle_ram_en", s_en, 0);
        m_live = 1;
      end else if (ds) begin
        chk("disp_ram_en", s_en, 1);
        chk("disp_ram_we", s_we, 0);
        chk("disp_ram_addr", s_addr, da);
        nxt_dv = 1;
        m_dd = gold[da];
        if (m_hold == 0 && cif.cpu_req) m_stalls = (m_stalls == MAXS) ? MAXS : m_stalls + 1;
      end else if (m_hold == 0 && cif.cpu_req) begin
        chk("cpu_ram_en", s_en, 1);
        chk("cpu_ram_we", s_we, cif.cpu_we);
        chk("cpu_ram_addr", s_addr, cif.cpu_addr);
        chk("cpu_ram_wdata", s_wdata, cif.cpu_wdata);
        nxt_ack = 1;
        m_ack_rd = !cif.cpu_we;
        if (cif.cpu_we) gold[cif.cpu_addr] = cif.cpu_wdata;
        else            m_rd = gold[cif.cpu_addr];
        m_hold = 3;
      end else begin
        chk("idle_ram_en", s_en, 0);
        chk("idle_ram_we", s_we, 0);
        chk("idle_ram_addr", s_addr, 0);
        chk("idle_ram_wdata", s_wdata, 0);
      end
      if (m_hold > 0) m_hold--;
      m_dv = nxt_dv;
      m_ack = nxt_ack;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (scan_en) begin
      if (hpos == 9'd339) begin
        hpos = 9'd0;
        vpos = (vpos == 9'd261) ? 9'd0 : vpos + 9'd1;
      end else begin
        hpos = hpos + 9'd1;
      end
    end
  endtask

  // Master behaviour: raise req, hold until ack, drop it for the following cycle.
  task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                        output int lat, output logic [DATA_W-1:0] rd, output int ack_h, output int ack_cyc);
    bit got;
    got = 0; lat = 0; rd = '0; ack_h = -1; ack_cyc = -1;
    cif.cpu_req = 1'b1; cif.cpu_we = we; cif.cpu_addr = addr; cif.cpu_wdata = wd;
    while (!got && lat < 20) begin
      cycle();
      lat++;
      if (s_ack) begin
        got = 1; rd = s_rd; ack_h = s_hpos; ack_cyc = cyc;
      end
    end
    cif.cpu_req = 1'b0;
    chk("cpu_ack_seen", got, 1);
    if (got) cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ah, ac, prev_ac, gap;
    logic [DATA_W-1:0] rd;
    logic [ADDR_W-1:0] a;

    salt = $urandom();
    for (int i = 0; i < (1 << ADDR_W); i++) gold[i] = seed_val(i, salt);
    seed_mem = 1'b1;
    reset = 1'b0; scan_en = 0;
    hpos = 9'd3; vpos = 9'd0;
    cif.cpu_req = 1'b1; cif.cpu_we = 1'b0; cif.cpu_addr = 10'h3FF; cif.cpu_wdata = 8'h00;
    sif.cpu_req = 1'b0; sif.cpu_we = 1'b0; sif.cpu_addr = '0; sif.cpu_wdata = '0;
    m_live = 0; m_dv = 0; m_ack = 0; m_ack_rd = 0; m_hold = 0; m_stalls = 0; m_dd = '0; m_rd = '0;
    @(posedge clk); #1;
    cycle();
    seed_mem = 1'b0;
    cycle(); cycle();

    // 1: reset held with a pending request, then release
    chk("t1_rst_ram_en", s_en, 0);
    chk("t1_rst_ack", s_ack, 0);
    reset = 1'b1;
    cycle();
    chk("t1_release_cycle_en", s_en, 0);
    cycle();
    chk("t1_first_access_en", s_en, 1);
    chk("t1_first_access_addr", s_addr, 10'h3FF);
    cycle();
    chk("t1_first_ack", s_ack, 1);
    chk("t1_first_rdata", s_rd, gold[10'h3FF]);
    cif.cpu_req = 1'b0;
    cycle();

    // 2: display fetch of cell (row 2, col 5)
    vpos = 9'd16; hpos = 9'd40;
    cycle();
    chk("t2_ram_en", s_en, 1);
    chk("t2_ram_addr", s_addr, 10'h045);
    hpos = 9'd41;
    cycle();
    chk("t2_disp_valid", s_dv, 1);
    chk("t2_disp_data", s_dd, gold[10'h045]);
    hpos = 9'd42;
    cycle();
    chk("t2_valid_pulse", s_dv, 0);

    // 3: CPU write then read-back away from slots
    hpos = 9'd3;
    cpu_op(1'b1, 10'h123, 8'hA5, lat, rd, ah, ac);
    chk("t3_write_latency", lat, 2);
    cpu_op(1'b0, 10'h123, 8'h00, lat, rd, ah, ac);
    chk("t3_read_latency", lat, 2);
    chk("t3_read_data", rd, 8'hA5);

    // 4: request lands on the first slot of the frame
    scan_en = 1; hpos = 9'd8; vpos = 9'd0;
    cpu_op(1'b0, 10'h010, 8'h00, lat, rd, ah, ac);
    chk("t4_latency", lat, 3);
    chk("t4_ack_hpos", ah, 10);
    chk("t4_stalls", s_stalls, 1);

    // 5: streaming reads in vblank / hblank
    hpos = 9'd248; vpos = 9'd240; prev_ac = -1;
    for (int k = 0; k < 4; k++) begin
      cpu_op(1'b0, 10'($urandom), 8'h00, lat, rd, ah, ac);
      chk("t5_latency", lat, 2);
      if (k > 0) chk("t5_ack_spacing", ac - prev_ac, 3);
      prev_ac = ac;
    end

    // 6a: stall counter saturation on the narrow instance
    scan_en = 0; hpos = 9'd0; vpos = 9'd0;
    sif.cpu_req = 1'b1;
    repeat (14) cycle();
    chk("t6_sat_count14", sat_stalls, 14);
    cycle();
    chk("t6_sat_allones", sat_stalls, 15);
    repeat (3) cycle();
    chk("t6_sat_holds", sat_stalls, 15);
    sif.cpu_req = 1'b0;
    hpos = 9'd3;
    cycle();

    // 6b: reset asserted while the CPU access is in flight
    cif.cpu_req = 1'b1; cif.cpu_we = 1'b0; cif.cpu_addr = 10'h055;
    cycle();
    chk("t6_issue_en", s_en, 1);
    reset = 1'b0;
    cycle();
    chk("t6_no_ack_in_reset", s_ack, 0);
    chk("t6_stalls_cleared", s_stalls, 0);
    cif.cpu_req = 1'b0;
    cycle();
    reset = 1'b1;
    cycle(); cycle();

    // Randomized traffic over a scanning raster
    scan_en = 1;
    for (int chunk = 0; chunk < 8; chunk++) begin
      hpos = 9'($urandom_range(0, 339));
      vpos = (chunk == 0) ? 9'd238 : 9'($urandom_range(0, 261));
      for (int n = 0; n < 60; n++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) cycle();
        a = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : 10'($urandom);
        cpu_op(1'($urandom), a, 8'($urandom), lat, rd, ah, ac);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
